apb_spi_master_mc: RTL and testbench

APB3/APB4 slave that drives a multi-chip-select SPI master with separate TX and RX FIFOs. This is the generalised successor of the single-CS byte-wide APB-to-SPI bridge. It adds configurable frame width, CPOL/CPHA mode, MSB/LSB-first order, a runtime clock divider, a chip-select selector and sticky error flags. It sits on the peripheral APB bus between the CPU interconnect and external SPI devices.

---
 rtl/apb_spi_master_mc.sv | 177 +++++++++++++++++
 tb/tb_apb_spi_master_mc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/apb_spi_master_mc.sv
// apb_spi_master_mc: APB slave driving a multi-chip-select SPI master with TX/RX FIFOs,
// configurable frame width, CPOL/CPHA, bit order and runtime clock divider.
module apb_spi_master_mc #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_CS = 4,
  parameter int DATA_W = 8,
  parameter int CLK_FREC = 50000000,
  parameter int SCL_FREC = 9600
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [31:0]       paddr,
  input  logic [2:0]        pprot,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic              pready,
  output logic [31:0]       prdata,
  output logic              pslverr,
  input  logic              miso,
  output logic              mosi,
  output logic              scl,
  output logic [NUM_CS-1:0] cs
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_FREC / (2 * SCL_FREC) - 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, FRAME_END, CS_HOLD} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [LW-1:0] tx_cnt, rx_cnt;
  logic [7:0] pend, pend_nx;
  logic [8:0] pend_sum;
  logic rx_ovf, lsb, cpha, cpol, hph, sclk, mosi_q, busy, cs_act;
  logic [4:0] len_m1, si, ni, tix, rix;
  logic [2:0] cs_idx;
  logic [15:0] div, cnt;
  logic [DATA_W-1:0] txd, rxd, frame;
  logic [5:0] e;
  logic [1:0] miso_s;
  logic [31:0] off, rdv;
  logic acc, err, ok, tx_push, rx_pop, pend_wr, ctrl_wr, div_wr, ovf_clr;
  logic tx_full, tx_empty, rx_full, rx_empty, half, last, work, more, load, tx_pop;
  logic pend_dec, rx_push, edge_t, samp, shft, unused;

  function automatic logic pick(input logic [DATA_W-1:0] f, input logic [4:0] i);
    pick = 1'b0;
    for (int k = 0; k < DATA_W; k++) if (5'(k) == i) pick = f[k];
  endfunction

  always_comb begin
    off = paddr - BASE_ADDR;
    acc = psel & penable;
    rdv = '0;
    err = 1'b0;
    case (off)
      32'h00: begin rdv = {tx_full, tx_empty, busy, 13'b0, 16'(tx_cnt)}; err = pwrite & tx_full; end
      32'h04: rdv = {rx_full, rx_empty, rx_ovf, 5'b0, pend, 16'(rx_cnt)};
      32'h08: begin rdv = 32'(rx_mem[rx_rp]); err = pwrite | rx_empty; end
      32'h0C: err = !pwrite;
      32'h10: begin
        rdv = {19'b0, len_m1, 1'b0, cs_idx, 1'b0, lsb, cpha, cpol};
        err = pwrite & (busy | ({27'b0, pwdata[12:8]} >= DATA_W) | ({29'b0, pwdata[6:4]} >= NUM_CS));
      end
      32'h14: begin rdv = {16'b0, div}; err = pwrite & busy; end
      default: err = 1'b1;
    endcase
  end

  assign ok = acc & !err;
  assign tx_push = ok & pwrite & (off == 32'h00);
  assign rx_pop = ok & !pwrite & (off == 32'h08);
  assign pend_wr = ok & pwrite & (off == 32'h0C);
  assign ctrl_wr = ok & pwrite & (off == 32'h10);
  assign div_wr = ok & pwrite & (off == 32'h14);
  assign ovf_clr = ok & pwrite & (off == 32'h04) & pwdata[29];
  assign pready = acc;
  assign pslverr = acc & err;
  assign prdata = (acc & !pwrite & !err) ? rdv : '0;
  assign unused = ^{pprot, pstrb, pwdata};

  assign tx_full = tx_cnt == FULL;
  assign tx_empty = tx_cnt == '0;
  assign rx_full = rx_cnt == FULL;
  assign rx_empty = rx_cnt == '0;
  assign half = cnt == div;
  assign last = e == {len_m1, 1'b1};
  assign work = !tx_empty | (pend != 8'd0);
  assign pend_dec = (state == FRAME_END) & (pend != 8'd0);
  assign pend_sum = {1'b0, pend} - {8'b0, pend_dec} + (pend_wr ? {1'b0, pwdata[7:0]} : 9'd0);
  assign pend_nx = pend_sum[8] ? 8'hFF : pend_sum[7:0];
  assign more = !tx_empty | (pend_nx != 8'd0);
  assign load = ((state == IDLE) & work) | ((state == FRAME_END) & more);
  assign tx_pop = load & !tx_empty;
  assign frame = tx_empty ? '0 : tx_mem[tx_rp];
  assign rx_push = pend_dec & !rx_full;
  // Even edges lead, odd edges trail; cpha selects which of the two samples.
  assign edge_t = (state == SHIFT) & half;
  assign samp = edge_t & (e[0] == cpha);
  assign shft = edge_t & (e[0] != cpha);
  assign si = e[5:1];
  assign ni = e[5:1] + {4'b0, e[0]};
  assign tix = lsb ? ni : len_m1 - ni;
  assign rix = lsb ? si : len_m1 - si;

  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = work ? CS_SETUP : IDLE;
      CS_SETUP:  state_nx = half ? SHIFT : CS_SETUP;
      SHIFT:     state_nx = (half & last) ? FRAME_END : SHIFT;
      FRAME_END: state_nx = more ? SHIFT : CS_HOLD;
      CS_HOLD:   state_nx = (half & hph) ? IDLE : CS_HOLD;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = state != IDLE;
    cs_act = (state == CS_SETUP) | (state == SHIFT) | (state == FRAME_END) | ((state == CS_HOLD) & !hph);
    cs = cs_act ? ~(NUM_CS'(1) << cs_idx) : '1;
    scl = sclk;
    mosi = mosi_q;
  end

  always_ff @(posedge pclk) begin
    if (tx_push) tx_mem[tx_wp] <= pwdata[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp] <= rxd;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      {tx_wp, tx_rp, rx_wp, rx_rp, tx_cnt, rx_cnt} <= '0;
      {pend, rx_ovf, len_m1, cs_idx, lsb, cpha, cpol} <= '0;
      div <= DIV_RST;
      {cnt, e, hph, sclk, mosi_q, miso_s, txd, rxd} <= '0;
    end else begin
      miso_s <= {miso_s[0], miso};
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
      pend <= pend_nx;
      if (pend_dec & rx_full) rx_ovf <= 1'b1;
      else if (ovf_clr) rx_ovf <= 1'b0;
      if (ctrl_wr) {len_m1, cs_idx, lsb, cpha, cpol} <= {pwdata[12:8], pwdata[6:4], pwdata[2:0]};
      if (div_wr) div <= pwdata[15:0];
      cnt <= (half | (state == IDLE) | (state == FRAME_END)) ? 16'd0 : cnt + 16'd1;
      hph <= (state == CS_HOLD) & (hph ^ half);
      if (state == IDLE) sclk <= cpol;
      if (edge_t) begin
        sclk <= ~sclk;
        e <= e + 6'd1;
      end
      if (shft) mosi_q <= pick(txd, tix);
      for (int k = 0; k < DATA_W; k++) if (samp && 5'(k) == rix) rxd[k] <= miso_s[1];
      if (load) begin
        txd <= frame;
        rxd <= '0;
        e <= '0;
        if (!cpha) mosi_q <= pick(frame, lsb ? 5'd0 : len_m1);
      end
    end
  end
endmodule

// File: tb/tb_apb_spi_master_mc.sv
// tb_apb_spi_master_mc: directed APB/SPI checks of apb_spi_master_mc with a bit-stream slave model.
module tb_apb_spi_master_mc;
  localparam int NCS = 4;
  logic pclk = 0, presetn = 0;
  logic [31:0] paddr = 0, pwdata = 0, prdata;
  logic [2:0] pprot = 0;
  logic [3:0] pstrb = 4'hF;
  logic psel = 0, penable = 0, pwrite = 0, pready, pslverr, miso, mosi, scl, last_rdy;
  logic [NCS-1:0] cs, cs_prev = '1;
  int n_chk = 0, n_pass = 0;
  int cap_n = 0, sl_base = 0, sl_k;
  logic [31:0] cap = 0;
  logic [15:0] resp = 0;
  int fall [NCS] = '{default: 0};
  int rise [NCS] = '{default: 0};

  apb_spi_master_mc #(.DATA_W(16)) dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .miso(miso), .mosi(mosi), .scl(scl), .cs(cs)
  );

  always #5 pclk = ~pclk;

  // Both tested modes sample on rising scl; the slave advances right after each sample.
  always @(posedge scl) begin
    cap = {cap[30:0], mosi};
    cap_n++;
  end

  always_comb begin
    sl_k = cap_n - sl_base;
    miso = (sl_k >= 0 && sl_k < 16) ? resp[4'(15 - sl_k)] : 1'b0;
  end

  always @(cs) begin
    for (int k = 0; k < NCS; k++) begin
      if (cs_prev[k] === 1'b1 && cs[k] === 1'b0) fall[k]++;
      if (cs_prev[k] === 1'b0 && cs[k] === 1'b1) rise[k]++;
    end
    cs_prev = cs;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er);
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1;
    #2;
    rd = prdata; er = pslverr; last_rdy = pready;
    @(posedge pclk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] r;
    logic er;
    r = '1;
    for (int i = 0; i < 3000 && r[29]; i++) apb(0, 32'h00, 0, r, er);
    chk(tag, {31'b0, r[29]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int c0, f0, r0, f1, f2, f3, errs;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_cs", {28'b0, cs}, 32'hF);
    chk("rst_scl", {31'b0, scl}, 32'd0);
    chk("rst_pready", {31'b0, pready}, 32'd0);
    presetn = 1;
    apb(0, 32'h00, 0, rd, er); chk("rst_txstat", rd, 32'h4000_0000);
    chk("rdy_access", {31'b0, last_rdy}, 32'd1);
    apb(0, 32'h14, 0, rd, er); chk("rst_div", rd, 32'd2603);
    apb(0, 32'h04, 0, rd, er); chk("rst_rxstat", rd, 32'h4000_0000);
    chk("rst_mosi", {31'b0, mosi}, 32'd0);

    // Mode 0, 8-bit, CS0, burst of two frames with read-back
    apb(1, 32'h10, 32'h700, rd, er); chk("m0_ctrl_err", {31'b0, er}, 32'd0);
    apb(1, 32'h14, 32'd1, rd, er);
    c0 = cap_n; sl_base = cap_n; resp = 16'h5AC3; f0 = fall[0]; r0 = rise[0];
    apb(1, 32'h00, 32'hA5, rd, er);
    apb(1, 32'h00, 32'h3C, rd, er);
    apb(1, 32'h0C, 32'd2, rd, er);
    wait_idle("m0_idle");
    chk("m0_nbits", 32'(cap_n - c0), 32'd16);
    chk("m0_mosi", {16'b0, cap[15:0]}, 32'hA53C);
    chk("m0_cs0_fall", 32'(fall[0] - f0), 32'd1);
    chk("m0_cs0_rise", 32'(rise[0] - r0), 32'd1);
    apb(0, 32'h04, 0, rd, er); chk("m0_rxstat", rd, 32'h0000_0002);
    apb(0, 32'h08, 0, rd, er); chk("m0_rx0", rd, 32'h5A);
    apb(0, 32'h08, 0, rd, er); chk("m0_rx1", rd, 32'hC3);

    // Mode 3, LSB first, 16-bit, CS2
    apb(1, 32'h10, 32'h0F27, rd, er); chk("m3_ctrl_err", {31'b0, er}, 32'd0);
    repeat (3) @(posedge pclk);
    c0 = cap_n; f0 = fall[0]; f1 = fall[1]; f2 = fall[2]; f3 = fall[3]; r0 = rise[2];
    #1 chk("m3_scl_idle_pre", {31'b0, scl}, 32'd1);
    apb(1, 32'h00, 32'h1234, rd, er);
    wait_idle("m3_idle");
    chk("m3_nbits", 32'(cap_n - c0), 32'd16);
    chk("m3_mosi", {16'b0, cap[15:0]}, 32'h2C48);
    chk("m3_cs2_fall", 32'(fall[2] - f2), 32'd1);
    chk("m3_cs2_rise", 32'(rise[2] - r0), 32'd1);
    chk("m3_other_cs", 32'(fall[0] - f0 + fall[1] - f1 + fall[3] - f3), 32'd0);
    chk("m3_scl_idle", {31'b0, scl}, 32'd1);
    apb(0, 32'h04, 0, rd, er); chk("m3_rxstat", rd, 32'h4000_0000);

    // Illegal configuration and unmapped access
    apb(1, 32'h10, 32'h1000, rd, er); chk("bad_len_err", {31'b0, er}, 32'd1);
    apb(1, 32'h10, 32'h0040, rd, er); chk("bad_cs_err", {31'b0, er}, 32'd1);
    apb(0, 32'h10, 0, rd, er); chk("ctrl_kept", rd, 32'h0F27);
    apb(0, 32'h18, 0, rd, er); chk("unmapped_err", {31'b0, er}, 32'd1);
    chk("unmapped_rdata", rd, 32'd0);

    // RX overflow with 20 dummy frames
    apb(1, 32'h10, 32'h700, rd, er);
    apb(1, 32'h14, 32'd0, rd, er);
    apb(1, 32'h0C, 32'd20, rd, er);
    wait_idle("ovf_idle");
    apb(0, 32'h04, 0, rd, er); chk("ovf_rxstat", rd, 32'hA000_0010);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      apb(0, 32'h08, 0, rd, er);
      errs += int'(er);
    end
    chk("drain_err", 32'(errs), 32'd0);
    apb(0, 32'h08, 0, rd, er); chk("pop_empty_err", {31'b0, er}, 32'd1);
    chk("pop_empty_rdata", rd, 32'd0);
    apb(1, 32'h04, 32'h2000_0000, rd, er);
    apb(0, 32'h04, 0, rd, er); chk("ovf_w1c", rd, 32'h4000_0000);

    // Slow frame in flight: fill TX, saturate pending, reject config writes, then reset
    apb(1, 32'h14, 32'hFFFF, rd, er);
    apb(1, 32'h00, 32'h11, rd, er);
    repeat (4) @(posedge pclk);
    apb(0, 32'h00, 0, rd, er); chk("slow_busy", rd, 32'h6000_0000);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      apb(1, 32'h00, 32'(i), rd, er);
      errs += int'(er);
    end
    chk("fill_err", 32'(errs), 32'd0);
    apb(1, 32'h00, 32'h99, rd, er); chk("push_full_err", {31'b0, er}, 32'd1);
    apb(0, 32'h00, 0, rd, er); chk("full_txstat", rd, 32'hA000_0010);
    apb(1, 32'h0C, 32'd200, rd, er);
    apb(1, 32'h0C, 32'd100, rd, er);
    apb(0, 32'h04, 0, rd, er); chk("pend_sat", rd, 32'h40FF_0000);
    apb(1, 32'h10, 32'h0001, rd, er); chk("ctrl_busy_err", {31'b0, er}, 32'd1);
    apb(0, 32'h10, 0, rd, er); chk("ctrl_busy_kept", rd, 32'h0700);
    apb(1, 32'h14, 32'd5, rd, er); chk("div_busy_err", {31'b0, er}, 32'd1);
    @(posedge pclk); #1;
    chk("pre_rst_cs", {28'b0, cs}, 32'hE);
    presetn = 0;
    #2;
    chk("midrst_cs", {28'b0, cs}, 32'hF);
    chk("midrst_scl", {31'b0, scl}, 32'd0);
    repeat (2) @(posedge pclk);
    #1 presetn = 1;
    apb(0, 32'h00, 0, rd, er); chk("post_rst_tx", rd, 32'h4000_0000);
    apb(0, 32'h04, 0, rd, er); chk("post_rst_rx", rd, 32'h4000_0000);
    apb(0, 32'h14, 0, rd, er); chk("post_rst_div", rd, 32'd2603);
    apb(0, 32'h10, 0, rd, er); chk("post_rst_ctrl", rd, 32'd0);
    chk("post_rst_cs", {28'b0, cs}, 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
